// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
package alu_serial_pkg;

  // Default operand and result width
  localparam int WIDTH_DEF = 32;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Operation class, carried in sel[3:2]
  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_SHR   = 2'b10;
  localparam logic [1:0] CLS_SHL   = 2'b11;

  // Logic operation, carried in sel[1:0] when the class is LOGIC
  localparam logic [1:0] LOP_AND  = 2'b00;
  localparam logic [1:0] LOP_OR   = 2'b01;
  localparam logic [1:0] LOP_XOR  = 2'b10;
  localparam logic [1:0] LOP_NOTA = 2'b11;

  // Full-adder carry: majority of three bits
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_alu_1bit.sv
// One-bit ALU slice: full adder with B conditioning, bitwise logic ops, and
// a pass-through of a_i used by the controller for shifts.
module alu_1bit
  import alu_serial_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [3:0] sel_i,
  output logic       f_o,
  output logic       cout_o
);

  logic bb_s;

  // Condition B for arithmetic: b, ~b, 0 or 1
  always_comb begin
    bb_s = b_i;
    case (sel_i[1:0])
      2'b00:   bb_s = b_i;
      2'b01:   bb_s = ~b_i;
      2'b10:   bb_s = 1'b0;
      2'b11:   bb_s = 1'b1;
      default: bb_s = b_i;
    endcase
  end

  // Compute the slice result and carry for the selected operation class
  always_comb begin
    f_o    = 1'b0;
    cout_o = 1'b0;
    case (sel_i[3:2])
      CLS_ARITH: begin
        f_o    = a_i ^ bb_s ^ c_i;
        cout_o = maj3(a_i, bb_s, c_i);
      end
      CLS_LOGIC: begin
        case (sel_i[1:0])
          LOP_AND:  f_o = a_i & b_i;
          LOP_OR:   f_o = a_i | b_i;
          LOP_XOR:  f_o = a_i ^ b_i;
          LOP_NOTA: f_o = ~a_i;
          default:  f_o = 1'b0;
        endcase
        cout_o = 1'b0;
      end
      CLS_SHR, CLS_SHL: begin
        f_o    = a_i;
        cout_o = 1'b0;
      end
      default: begin
        f_o    = 1'b0;
        cout_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: accepts a request, walks one alu_1bit slice
// across the operands LSB first, and returns the result over a handshake.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             cin_i,
  input  logic [3:0]       sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_r;
  state_e           state_nx_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       sel_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             cout_r;
  logic             zero_r;

  logic             accept_s;
  logic             last_s;
  logic             is_arith_s;
  logic [WIDTH-1:0] a_shr_s;
  logic [WIDTH-1:0] a_shl_s;
  logic [WIDTH-1:0] result_nx_s;
  logic             slice_a_s;
  logic             slice_b_s;
  logic             slice_f_s;
  logic             slice_cout_s;
  logic             cout_final_s;

  // Flush blocks acceptance so a simultaneous request is simply not taken
  assign accept_s   = (state_r == ST_IDLE) & req_valid_i & ~flush_i;
  assign last_s     = (cnt_r == CNT_LAST);
  assign is_arith_s = (sel_r[3:2] == CLS_ARITH);

  // Neighbour vectors for shifts: index cnt picks A[cnt+1] or A[cnt-1],
  // with zero filled in at the vacated end
  assign a_shr_s = {1'b0, a_r[WIDTH-1:1]};
  assign a_shl_s = {a_r[WIDTH-2:0], 1'b0};

  // Each step's slice output enters at the MSB; after WIDTH steps the
  // first computed bit has arrived at bit 0
  assign result_nx_s = {slice_f_s, result_r[WIDTH-1:1]};

  // Select the A bit presented to the slice: own bit or shift neighbour
  always_comb begin
    slice_a_s = a_r[cnt_r];
    case (sel_r[3:2])
      CLS_ARITH: slice_a_s = a_r[cnt_r];
      CLS_LOGIC: slice_a_s = a_r[cnt_r];
      CLS_SHR:   slice_a_s = a_shr_s[cnt_r];
      CLS_SHL:   slice_a_s = a_shl_s[cnt_r];
      default:   slice_a_s = 1'b0;
    endcase
  end

  assign slice_b_s = b_r[cnt_r];

  alu_1bit u_slice (
    .a_i    (slice_a_s),
    .b_i    (slice_b_s),
    .c_i    (carry_r),
    .sel_i  (sel_r),
    .f_o    (slice_f_s),
    .cout_o (slice_cout_s)
  );

  // Carry-out reported in DONE depends on the operation class
  always_comb begin
    cout_final_s = 1'b0;
    case (sel_r[3:2])
      CLS_ARITH: cout_final_s = slice_cout_s;
      CLS_LOGIC: cout_final_s = 1'b0;
      CLS_SHR:   cout_final_s = a_r[0];
      CLS_SHL:   cout_final_s = a_r[WIDTH-1];
      default:   cout_final_s = 1'b0;
    endcase
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_nx_s = state_r;
    if (flush_i) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (last_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        ST_DONE: begin
          if (rsp_ready_i) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, bit stepping and result/flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      sel_r    <= 4'b0000;
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      zero_r   <= 1'b1;
    end else if (flush_i) begin
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      zero_r   <= 1'b1;
    end else if (accept_s) begin
      a_r     <= op_a_i;
      b_r     <= op_b_i;
      sel_r   <= sel_i;
      carry_r <= (sel_i[3:2] == CLS_ARITH) ? cin_i : 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      result_r <= result_nx_s;
      if (is_arith_s) begin
        carry_r <= slice_cout_s;
      end
      if (last_s) begin
        cnt_r  <= {CNT_W{1'b0}};
        cout_r <= cout_final_s;
        zero_r <= (result_nx_s == {WIDTH{1'b0}});
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign req_ready_o = (state_r == ST_IDLE);
  assign rsp_valid_o = (state_r == ST_DONE);
  assign busy_o      = (state_r == ST_RUN);
  assign result_o    = result_r;
  assign cout_o      = cout_r;
  assign zero_o      = zero_r;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl at WIDTH = 32.
module tb_alu_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        cin = 1'b0;
  logic [3:0]  sel = 4'b0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] result;
  logic        cout;
  logic        zero;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .cin_i       (cin),
    .sel_i       (sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .result_o    (result),
    .cout_o      (cout),
    .zero_o      (zero),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for rsp_valid after acceptance; returns cycles counted (bounded)
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  // Full operation with scrambled inputs after acceptance
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [3:0] s,
                        input logic [31:0] exp_res, input logic exp_cout);
    int cyc;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    op_a = a; op_b = b; cin = c; sel = s; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; op_a = ~a; op_b = ~b; cin = ~c; sel = ~s;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_rsp(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd32);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    chk({tag, "_zero"}, 32'(zero), 32'(exp_res == 32'h0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle_after"}, {30'h0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    logic seen;

    // Reset values
    #7;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid_busy", {30'h0, rsp_valid, busy}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    tick();

    // Main function
    run_op("add",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'b0000, 32'h0000_0000, 1'b1);
    run_op("sub",   32'h0000_0005, 32'h0000_0007, 1'b1, 4'b0001, 32'hFFFF_FFFE, 1'b0);
    run_op("dec",   32'h0000_0010, 32'h1234_5678, 1'b0, 4'b0011, 32'h0000_000F, 1'b1);
    run_op("and",   32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 4'b0100, 32'hF000_F000, 1'b0);
    run_op("or",    32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 4'b0101, 32'hFFF0_FFF0, 1'b0);
    run_op("xor",   32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 4'b0110, 32'h0FF0_0FF0, 1'b0);
    run_op("nota",  32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0111, 32'hFFFF_FFFF, 1'b0);
    run_op("shr",   32'h8000_0001, 32'h0000_0000, 1'b0, 4'b1000, 32'h4000_0000, 1'b1);
    run_op("shl",   32'h8000_0001, 32'h0000_0000, 1'b0, 4'b1111, 32'h0000_0002, 1'b1);

    // Backpressure with a second request pending
    op_a = 32'd1; op_b = 32'd1; cin = 1'b0; sel = 4'b0000; req_valid = 1'b1;
    tick();
    op_a = 32'd10; op_b = 32'd20;
    wait_rsp(cyc);
    chk("bp_latency", 32'(cyc), 32'd32);
    for (int i = 0; i < 10; i++) begin
      chk("bp_result_stable", result, 32'd2);
      chk("bp_valid_noready", {30'h0, rsp_valid, req_ready}, 32'd2);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_after_hs", {30'h0, rsp_valid, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_second_accepted", 32'(busy), 32'd1);
    wait_rsp(cyc);
    chk("bp2_latency", 32'(cyc), 32'd32);
    chk("bp2_result", result, 32'd30);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Flush at RUN cycle 10
    op_a = 32'h0; op_b = 32'h0; cin = 1'b0; sel = 4'b0111; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {29'h0, busy, rsp_valid, req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    chk("flush_no_rsp", 32'(seen), 32'd0);

    // Flush wins over a simultaneous request in IDLE
    req_valid = 1'b1; flush = 1'b1; op_a = 32'd7; sel = 4'b0000;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_req", {30'h0, busy, req_ready}, 32'd1);

    // Asynchronous reset mid-RUN
    op_a = 32'h0; op_b = 32'h0; cin = 1'b0; sel = 4'b0111; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("prerst_result_nonzero", 32'(result != 32'h0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {29'h0, busy, rsp_valid, req_ready}, 32'd1);
    chk("midrst_result", result, 32'h0);
    chk("midrst_flags", {30'h0, cout, zero}, 32'd1);
    #1;
    rst_n = 1'b1;
    tick();

    run_op("add_after", 32'd2, 32'd3, 1'b0, 4'b0000, 32'd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial sequencer that performs WIDTH-bit ALU operations by stepping one `alu_1bit` slice through the operand, LSB first, one bit per clock. It accepts a request over a valid/ready handshake, runs WIDTH cycles, and returns the result over a second valid/ready handshake. It is the minimum-area alternative to the parallel 32-bit ALU and sits between the instruction/command source and the register write-back.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 2.
- `CNT_W`, `$clog2(WIDTH)`: bit-counter width; derived, not overridden.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous abort; returns the block to IDLE.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready; high only in IDLE.
- `op_a_i`  in  WIDTH  operand A.
- `op_b_i`  in  WIDTH  operand B.
- `cin_i`  in  1  arithmetic carry-in.
- `sel_i`  in  4  op select; same encoding as `alu_1bit`.
- `rsp_valid_o`  out  1  result valid; high only in DONE.
- `rsp_ready_i`  in  1  result consumed.
- `result_o`  out  WIDTH  result; stable while `rsp_valid_o` is high.
- `cout_o`  out  1  carry-out or shifted-out bit.
- `zero_o`  out  1  high when `result_o` is 0; qualified by `rsp_valid_o`.
- `busy_o`  out  1  high in RUN.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `req_valid_i & req_ready_o & !flush_i` latches A, B, `sel` and the carry, clears `cnt`, and moves to RUN.
  - The carry register loads `cin_i` when `sel[3:2]` is 00, otherwise 0.
- **RUN**
  - Each cycle drives the slice with bit `cnt`.
  - The slice's `f_o` is shifted into the MSB of the result register (shift right), so the result is LSB-aligned after WIDTH steps.
  - For arithmetic ops, `cout_o` of the slice updates the carry register.
  - At `cnt == WIDTH-1` the FSM moves to DONE.
- **DONE**
  - Holds `result_o`, `cout_o` and `zero_o`.
  - `rsp_valid_o & rsp_ready_i` moves the FSM to IDLE.
- Slice function per bit (`bb` = b, ~b, 0, 1 for `sel[1:0]` = 00, 01, 10, 11):
  - Arithmetic (`sel[3:2]` = 00): f = a^bb^c; carry = majority(a, bb, c). For example, 0001 with cin=1 gives A−B, and 0011 with cin=0 gives A−1.
  - Logic (`sel[3:2]` = 01): AND, OR, XOR, NOT A for `sel[1:0]` = 00, 01, 10, 11.
  - Shift (`sel[3]` = 1): the controller presents the neighbour bit on `a_i` and the slice returns `f = a_i`.
    - SHR (`sel[3:2]` = 10): feeds A[cnt+1], with 0 at the MSB.
    - SHL (`sel[3:2]` = 11): feeds A[cnt−1], with 0 at the LSB.
    - `sel[1:0]` is ignored.
- `cout_o` per op class:
  - Arithmetic: final carry.
  - Logic: 0.
  - SHR: A[0]. SHL: A[WIDTH−1].
- No overlap: a new request is never accepted before the previous response handshake completes.
- Boundary conditions:
  - `flush_i` in any state forces IDLE on the next edge and discards the result. No `rsp_valid_o` pulse is produced.
  - `flush_i` together with `req_valid_i` in IDLE: flush wins, and the request is not accepted.
  - `rst_ni` low mid-RUN: immediate return to IDLE with all registers reset.
  - Inputs changing after acceptance have no effect.

## Timing
- Reset values:
  - State: IDLE.
  - `req_ready_o` = 1.
  - `rsp_valid_o`, `busy_o`, `cout_o` = 0.
  - `result_o` = 0; `zero_o` = 1 (not qualified).
  - `cnt` and carry = 0.
- Latency: acceptance at edge T gives `rsp_valid_o` = 1 after edge T+WIDTH, i.e. exactly WIDTH cycles (32 at default).
- Throughput: one operation per WIDTH+2 cycles with `rsp_ready_i` held high.
  - The cycle after the response handshake is IDLE with `req_ready_o` = 1.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- Package `alu_serial_pkg` holds:
  - The state enum (IDLE, RUN, DONE).
  - `sel[3:2]` class constants: ARITH = 00, LOGIC = 01, SHR = 10, SHL = 11.
  - The `sel[1:0]` logic-op constants.
  - `WIDTH` default.
- One sub-module: a single `alu_1bit` instance. The controller holds all registers, the bit-select mux and the shift neighbour mux.

## Test plan
- **ADD:** A=0xFFFFFFFF, B=0x1, cin=0, sel=0000 → result 0x0, `cout_o`=1, `zero_o`=1; `rsp_valid_o` rises exactly 32 cycles after acceptance.
- **SUB:** A=5, B=7, cin=1, sel=0001 → result 0xFFFFFFFE, `cout_o`=0.
- **XOR:** A=0xF0F0F0F0, B=0xFF00FF00, sel=0110 → 0x0FF00FF0, `cout_o`=0. NOT A with A=0 → 0xFFFFFFFF.
- **Shifts:** A=0x80000001 with sel=1000 → 0x40000000, `cout_o`=1. Same A with sel=1111 → 0x00000002, `cout_o`=1.
- **Backpressure:** `rsp_ready_i` held low 10 cycles in DONE with a second `req_valid_i` pending → result stable and `req_ready_o`=0. The second request is accepted one cycle after the response handshake.
- **Abort:** `flush_i` pulse at RUN cycle 10 → IDLE next cycle with `req_ready_o`=1 and no `rsp_valid_o`. Repeat with `rst_ni` low mid-RUN → all reset values immediately. A following ADD of 2+3 returns 5.
